// File: rtl/tpu_c_drain.sv
// rtl/tpu_c_drain.sv - drains global buffer C words as four 32-bit stream beats each
// One 128-bit word is read, captured, then sent lane 0 first; sm_tready never feeds sm_tvalid/sm_tdata.
module tpu_c_drain #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_BITS  = 32,
  parameter int DATAC_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            M,
  input  logic [7:0]            N,
  output logic                  busy,
  output logic                  done,
  output logic                  C_rd_en,
  output logic [ADDR_BITS-1:0]  C_index,
  input  logic [DATAC_BITS-1:0] C_data_out,
  output logic                  sm_tvalid,
  output logic [DATA_BITS-1:0]  sm_tdata,
  output logic                  sm_tlast,
  input  logic                  sm_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [15:0]            r_wc;
  logic [ADDR_BITS-1:0]   r_widx;
  logic [1:0]             r_lane;
  logic [DATAC_BITS-1:0]  r_word;

  logic [8:0]             w_n_plus;
  logic [15:0]            w_wc_in;
  logic [ADDR_BITS-1:0]   w_last_idx;
  logic                   w_last_word;
  logic                   w_hs;

  // Each row of N columns occupies ceil(N/4) buffer words.
  assign w_n_plus    = {1'b0, N} + 9'd3;
  assign w_wc_in     = {8'd0, M} * {9'd0, w_n_plus[8:2]};
  assign w_last_idx  = ADDR_BITS'(r_wc - 16'd1);
  assign w_last_word = (r_widx == w_last_idx);
  assign w_hs        = (r_state == S_SEND) && sm_tready;

  assign C_index  = r_widx;
  assign sm_tdata = r_word[32'(r_lane) * DATA_BITS +: DATA_BITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (w_wc_in == 16'd0) ? S_DONE : S_READ;
        end
      end
      S_READ:  w_next = S_CAPT;
      S_CAPT:  w_next = S_SEND;
      S_SEND: begin
        if (w_hs && (r_lane == 2'd3)) begin
          w_next = w_last_word ? S_DONE : S_READ;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    C_rd_en   = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    case (r_state)
      S_READ: C_rd_en = 1'b1;
      S_SEND: begin
        sm_tvalid = 1'b1;
        sm_tlast  = (r_lane == 2'd3) && w_last_word;
      end
      S_DONE: done = 1'b1;
      default: begin
        done = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wc   <= '0;
      r_widx <= '0;
      r_lane <= '0;
      r_word <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wc   <= w_wc_in;
            r_widx <= '0;
          end
        end
        S_CAPT: begin
          r_word <= C_data_out;
          r_lane <= '0;
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_lane != 2'd3) begin
              r_lane <= r_lane + 2'd1;
            end else if (!w_last_word) begin
              r_widx <= r_widx + 1'b1;
            end
          end
        end
        default: begin
          r_lane <= r_lane;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_c_drain.sv
// tb/tb_tpu_c_drain.sv - scoreboard bench for tpu_c_drain
module tb_tpu_c_drain;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   M;
  logic [7:0]   N;
  logic         busy;
  logic         done;
  logic         C_rd_en;
  logic [15:0]  C_index;
  logic [127:0] C_data_out;
  logic         sm_tvalid;
  logic [31:0]  sm_tdata;
  logic         sm_tlast;
  logic         sm_tready;

  tpu_c_drain dut (
    .clk(clk), .rst(rst), .start(start), .M(M), .N(N),
    .busy(busy), .done(done), .C_rd_en(C_rd_en), .C_index(C_index),
    .C_data_out(C_data_out), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
    .sm_tlast(sm_tlast), .sm_tready(sm_tready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0 = 0;
  int mon_rel;
  int first_rd, first_valid, last_hs, done_rel, done_cnt, rd_cnt, valid_cnt, busy_cnt, beats, exp_idx;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [32:0] sb[$];
  logic [32:0] sb_item;
  logic [127:0] mem [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer C model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (C_rd_en) C_data_out <= mem[C_index[3:0]];
    else         C_data_out <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    mon_rel = cyc - t0 + 1;
    if (!rst) begin
      if (C_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = mon_rel;
        check("c_index", C_index, exp_idx);
        exp_idx++;
      end
      if (sm_tvalid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = mon_rel;
      end
      if (prev_stall) begin
        check("stall_valid", sm_tvalid, 1);
        check("stall_data", sm_tdata, prev_data);
        check("stall_last", sm_tlast, prev_last);
      end
      if (sm_tvalid && sm_tready) begin
        beats++;
        last_hs = mon_rel;
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          sb_item = sb.pop_front();
          check("beat_data", sm_tdata, sb_item[31:0]);
          check("beat_last", sm_tlast, sb_item[32]);
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = mon_rel;
      end
      if (busy) busy_cnt++;
      prev_stall = sm_tvalid && !sm_tready;
      prev_data  = sm_tdata;
      prev_last  = sm_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_drain(input int m, input int n);
    int wc;
    wc = m * ((n + 3) / 4);
    for (int w = 0; w < wc; w++)
      for (int l = 0; l < 4; l++)
        sb.push_back({(w == wc - 1) && (l == 3), mem[w][32*l +: 32]});
    first_rd = -1; first_valid = -1; last_hs = -1; done_rel = -1;
    done_cnt = 0; rd_cnt = 0; valid_cnt = 0; busy_cnt = 0; beats = 0; exp_idx = 0;
    @(posedge clk); #1;
    M = 8'(m); N = 8'(n); start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
    M = 8'($urandom); N = 8'($urandom);
  endtask

  function automatic logic stall_sched(input int r);
    if (r <= 3) return 1'b1;
    if (r <= 8) return 1'b0;
    if (r == 10 || r == 12) return 1'b0;
    return 1'b1;
  endfunction

  // mode 0: ready held high; 1: stall pattern on beat 2; 2: stray start during SEND
  task automatic run(input int mode);
    int r;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      r = cyc - t0 + 1;
      sm_tready = (mode == 1) ? stall_sched(r) : 1'b1;
      start = (mode == 2) && (r == 5);
      if (done_cnt > 0 && r > done_rel + 1) break;
    end
    start = 1'b0;
    sm_tready = 1'b1;
    check("done_count", done_cnt, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; M = '0; N = '0; sm_tready = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", C_rd_en, 0);
    check("rst_tvalid", sm_tvalid, 0);
    check("rst_tlast", sm_tlast, 0);
    check("rst_index", C_index, 0);
    check("rst_tdata", sm_tdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single word, ready always high
    mem[0] = 128'h00000004_00000003_00000002_00000001;
    start_drain(1, 4);
    run(0);
    check("t1_first_rd", first_rd, 1);
    check("t1_first_valid", first_valid, 3);
    check("t1_last_hs", last_hs, 6);
    check("t1_done_rel", done_rel, 7);
    check("t1_busy_cycles", busy_cnt, 7);
    check("t1_rd_cnt", rd_cnt, 1);

    // M=2, N=5 -> four words, lanes tagged by word index
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mem[i][32*j +: 32] = {28'(i), 4'(j)};
    start_drain(2, 5);
    run(0);
    check("t2_rd_cnt", rd_cnt, 4);
    check("t2_beats", beats, 16);
    check("t2_done_rel", done_rel, 25);

    // Backpressure on beat 2
    mem[0] = 128'h00000004_00000003_00000002_00000001;
    start_drain(1, 4);
    run(1);
    check("t3_beats", beats, 4);
    check("t3_last_hs", last_hs, 13);
    check("t3_done_after_hs", done_rel, last_hs + 1);

    // Zero words
    start_drain(0, 7);
    run(0);
    check("t4_rd_cnt", rd_cnt, 0);
    check("t4_valid_cnt", valid_cnt, 0);
    check("t4_done_rel", done_rel, 1);
    check("t4_busy_cycles", busy_cnt, 1);

    // Reset in the middle of word 1
    for (int i = 0; i < 3; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    start_drain(3, 4);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (beats >= 6) break;
    end
    check("t5_beats_before_rst", beats, 6);
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_tvalid", sm_tvalid, 0);
    check("t5_rd_en", C_rd_en, 0);
    check("t5_done", done, 0);
    check("t5_tdata", sm_tdata, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("t5_no_done", done_cnt, 0);
    start_drain(1, 4);
    run(0);
    check("t5_restart_rd", first_rd, 1);
    check("t5_restart_rd_cnt", rd_cnt, 1);

    // Stray start while sending a two-word drain
    mem[0] = 128'h0000000d_0000000c_0000000b_0000000a;
    mem[1] = 128'h0000001d_0000001c_0000001b_0000001a;
    start_drain(1, 8);
    run(2);
    check("t6_beats", beats, 8);
    check("t6_rd_cnt", rd_cnt, 2);
    check("t6_done_rel", done_rel, 13);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
